// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: request/result handshake bundle between the core and the multi-cycle shifter
interface shift_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_sh;
    logic [7:0]  in_amt;
    logic        in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_carry;
    logic        busy;
    modport master (
        output in_valid, in_data, in_sh, in_amt, in_carry, out_ready,
        input  in_ready, out_valid, out_result, out_carry, busy
    );
    modport slave (
        input  in_valid, in_data, in_sh, in_amt, in_carry, out_ready,
        output in_ready, out_valid, out_result, out_carry, busy
    );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: ARM shift-by-register (LSL/LSR/ASR/ROR) executed STEP bits per cycle
module shift_sequencer #(
    parameter int STEP = 4
) (
    input logic clk,
    input logic reset,
    input logic flush,
    shift_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [1:0] LSL = 2'b00, LSR = 2'b01, ROR = 2'b11;
    state_t state, next;
    logic [31:0] data, step_data, asr_data;
    logic [63:0] rot_data;
    logic [1:0] sh;
    logic [5:0] rem, rem_in, k;
    logic carry, over, step_carry, accept, rot32;
    assign accept = state == IDLE && bus.in_valid;
    assign rot32 = bus.in_sh == ROR && bus.in_amt != 8'd0 && bus.in_amt[4:0] == 5'd0;
    assign asr_data = $signed(data) >>> k;
    assign rot_data = {data, data} >> k;
    // Amount remaining at accept: rotations wrap modulo 32, other shifts saturate at 32
    always_comb begin
        rem_in = bus.in_sh == ROR ? {1'b0, bus.in_amt[4:0]}
               : (bus.in_amt > 8'd32 ? 6'd32 : bus.in_amt[5:0]);
        k = rem < 6'(STEP) ? rem : 6'(STEP);
    end
    // One shift step of k bits; carry is the last bit shifted out, forced low for oversized LSL/LSR
    always_comb begin
        step_data = sh == LSL ? data << k
                  : sh == LSR ? data >> k
                  : sh == ROR ? rot_data[31:0]
                  : asr_data;
        step_carry = over ? 1'b0
                   : sh == LSL ? data[5'(6'd32 - k)]
                   : data[5'(k - 6'd1)];
    end
    // State register; reset and flush both abort to IDLE
    always_ff @(posedge clk) begin
        if (reset || flush) state <= IDLE;
        else state <= next;
    end
    // Next state
    always_comb begin
        next = state;
        case (state)
            IDLE:    if (bus.in_valid) next = rem_in != 6'd0 ? SHIFT : DONE;
            SHIFT:   if (rem == k) next = DONE;
            DONE:    if (bus.out_ready) next = IDLE;
            default: next = IDLE;
        endcase
    end
    // Operand latch and per-cycle shift datapath; data doubles as the registered result
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            data  <= 32'd0;
            carry <= 1'b0;
            rem   <= 6'd0;
            sh    <= 2'b00;
            over  <= 1'b0;
        end else if (accept) begin
            data  <= bus.in_data;
            sh    <= bus.in_sh;
            rem   <= rem_in;
            over  <= !bus.in_sh[1] && bus.in_amt > 8'd32;
            carry <= rot32 ? bus.in_data[31] : bus.in_carry;
        end else if (state == SHIFT) begin
            data  <= step_data;
            carry <= step_carry;
            rem   <= rem - k;
        end
    end
    // Handshake and status outputs decoded from state
    always_comb begin
        bus.in_ready   = state == IDLE;
        bus.out_valid  = state == DONE;
        bus.busy       = state != IDLE;
        bus.out_result = data;
        bus.out_carry  = carry;
    end
endmodule
